ecc_syndrome_stage: RTL and testbench
=====================================

Name: ecc_syndrome_stage

Overview:
- Pipelined SEC-DED syndrome and error-locator stage for the 13-bit Hamming(13,8) decoder.
- Sits directly upstream of the 13-bit XOR corrector stage.
- Accepts received codewords and emits each codeword with a 13-bit error mask, so the corrector computes corrected = out_cw ^ out_mask.
- Also flags uncorrectable words and keeps saturating error statistics.

Parameters:
- CNT_W, 16, width of the corrected-error and uncorrectable-error counters (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_cw is valid this cycle.
- in_ready  output  1  stage can accept a word this cycle.
- in_cw  input  13  received codeword.
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  downstream corrector accepts the word.
- out_cw  output  13  received codeword, delayed and unmodified.
- out_mask  output  13  one-hot error location, or zero.
- out_sec  output  1  single error located; mask is nonzero.
- out_ded  output  1  uncorrectable error; mask is zero.
- cnt_clr  input  1  synchronous clear of both counters.
- sec_cnt  output  CNT_W  count of accepted words with sec=1.
- ded_cnt  output  CNT_W  count of accepted words with ded=1.

Behaviour:
- Clocking: single clock domain.
- Reset: reset_n is asynchronous and active-low. While low, all registers clear: both stage valids=0, out_cw=0, out_mask=0, out_sec=0, out_ded=0, sec_cnt=0, ded_cnt=0. in_ready is combinational and reads 1 immediately after reset. A reset mid-operation discards all in-flight words with no output.
- Code layout:
  - in_cw[12:1] are Hamming positions 1..12; parity bits sit at indices 1, 2, 4 and 8.
  - in_cw[0] is overall even parity over all 13 bits.
- Stage 1 (S1 register), on accept:
  - Latches cw.
  - Latches s[3:0], where s[k] = XOR of cw[p] for p=1..12 with bit k of p set.
  - Latches pa = XOR of cw[12:0].
- Stage 2 (S2 register, drives out_*): classification from S1.
  - s=0, pa=0: clean. mask=0, sec=0, ded=0.
  - s=0, pa=1: overall-parity bit error. mask=13'h0001, sec=1.
  - s in 1..12, pa=1: single error. mask=1<<s, sec=1.
  - s in 13..15, pa=1: invalid position. mask=0, ded=1.
  - s!=0, pa=0: double error. mask=0, ded=1.
  - sec and ded are never both 1.
- Latency: 2 cycles from accept (in_valid&in_ready) to out_valid, with no backpressure.
- Handshake:
  - Standard valid/ready. A transfer occurs when valid&ready on the same edge.
  - s2_free = !out_valid | out_ready.
  - s1_free = !s1_valid | s2_free.
  - in_ready = s1_free (combinational, no in_valid dependence).
- Full throughput: with out_ready held at 1, one word per cycle and no bubbles.
- Stall: while out_valid=1 and out_ready=0, all out_* are held stable and S1 is held. in_ready drops once S1 is also occupied. Two words are buffered at most.
- Ordering: words emerge in acceptance order. No word is dropped or duplicated.
- Counters:
  - sec_cnt and ded_cnt increment on the output handshake edge (out_valid&out_ready) when out_sec or out_ded is set, respectively.
  - Both saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.

Test Plan:
- Clean word: reset, send in_cw=13'h0000 with out_ready=1. out_valid rises 2 cycles after accept with out_mask=0, sec=0, ded=0, out_cw=13'h0000. Counters stay 0.
- Single and parity-bit errors: send 13'h0020, then 13'h0001 back-to-back. Expect mask=13'h0020 with sec=1 on the first word and mask=13'h0001 with sec=1 on the second, on consecutive cycles. sec_cnt=2.
- Uncorrectable words:
  - Send 13'h0028 (double error, s=6, pa=0): expect mask=0, ded=1.
  - Send 13'h0112 (s=13, pa=1): expect mask=0, ded=1.
  - After both, ded_cnt=2.
- Backpressure: stream words 1..5 (values 13'h0000, 13'h0004, 13'h0000, 13'h0100, 13'h0000) while out_ready=0 for 4 cycles.
  - in_ready falls after 2 words are accepted.
  - out_* stay stable during the stall.
  - On release, all 5 words emerge in order with correct masks (0, 13'h0004, 0, 13'h0100, 0).
- Counter saturation and clear: build with CNT_W=2 and send 5 single-error words. sec_cnt reaches 3 and holds. Assert cnt_clr on the same cycle as a sec handshake; sec_cnt=0.
- Reset mid-stream: drop reset_n asynchronously while both stages hold words. out_valid=0 and all outputs are 0 immediately. After release, no stale word appears, and a new 13'h0020 yields mask=13'h0020.

Source files
------------

// File: rtl/ecc_syndrome_stage_if.sv
// Stream bundle around the SEC-DED syndrome stage: received words in,
// codeword plus error mask out toward the XOR corrector.
interface ecc_syndrome_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_cw;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_cw;
    logic [12:0] out_mask;
    logic        out_sec;
    logic        out_ded;

    // slave: the syndrome stage itself
    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_cw, out_mask, out_sec, out_ded
    );

    // master: upstream source plus downstream corrector
    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_cw, out_mask, out_sec, out_ded
    );
endinterface

// File: rtl/ecc_syndrome_stage.sv
// Two-stage SEC-DED syndrome / error-locator for Hamming(13,8) words with
// valid/ready flow control and saturating corrected/uncorrectable counters.
module ecc_syndrome_stage #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    ecc_syndrome_stage_if.slave bus,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    sec_cnt,
    output logic [CNT_W-1:0]    ded_cnt
);

    typedef struct packed {
        logic [12:0] cw;
        logic [3:0]  s;
        logic        pa;
    } s1_t;

    typedef struct packed {
        logic [12:0] cw;
        logic [12:0] mask;
        logic        sec;
        logic        ded;
    } s2_t;

    // s[k] folds every Hamming position whose index has bit k set
    function automatic s1_t syndrome(input logic [12:0] cw);
        s1_t r;
        r.cw = cw;
        r.s  = '0;
        for (int k = 0; k < 4; k++) begin
            for (int p = 1; p <= 12; p++) begin
                if (p[k]) r.s[k] = r.s[k] ^ cw[p];
            end
        end
        r.pa = ^cw;
        return r;
    endfunction

    function automatic s2_t classify(input s1_t r);
        s2_t o;
        o      = '0;
        o.cw   = r.cw;
        if (r.pa) begin
            if (r.s == 4'd0) begin
                o.mask = 13'h0001;
                o.sec  = 1'b1;
            end else if (r.s <= 4'd12) begin
                o.mask = 13'd1 << r.s;
                o.sec  = 1'b1;
            end else begin
                o.ded  = 1'b1;
            end
        end else if (r.s != 4'd0) begin
            o.ded = 1'b1;
        end
        return o;
    endfunction

    logic s1_vld, s2_vld;
    s1_t  s1;
    s2_t  s2;
    logic s1_free, s2_free, out_hs;

    assign s2_free      = !s2_vld || bus.out_ready;
    assign s1_free      = !s1_vld || s2_free;
    assign bus.in_ready = s1_free;
    assign out_hs       = s2_vld && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else if (s1_free) begin
            s1_vld <= bus.in_valid;
            if (bus.in_valid) s1 <= syndrome(bus.in_cw);
        end
    end

    // S2 only advances when the corrector has taken (or never had) its word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld <= 1'b0;
            s2     <= '0;
        end else if (s2_free) begin
            s2_vld <= s1_vld;
            if (s1_vld) s2 <= classify(s1);
        end
    end

    assign bus.out_valid = s2_vld;
    assign bus.out_cw    = s2.cw;
    assign bus.out_mask  = s2.mask;
    assign bus.out_sec   = s2.sec;
    assign bus.out_ded   = s2.ded;

    // clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (out_hs) begin
            if (s2.sec && !(&sec_cnt)) sec_cnt <= sec_cnt + CNT_W'(1);
            if (s2.ded && !(&ded_cnt)) ded_cnt <= ded_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc_syndrome_stage.sv
// Directed bench for ecc_syndrome_stage: scoreboard model checked every
// cycle plus literal expectations; a CNT_W=2 twin covers counter saturation.
module tb_ecc_syndrome_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] sec_cnt, ded_cnt;
    logic [1:0]  sec_cnt_s, ded_cnt_s;
    int          total = 0;
    int          bad = 0;

    ecc_syndrome_stage_if bus ();
    ecc_syndrome_stage_if bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_cw     = bus.in_cw;
    assign bus2.out_ready = bus.out_ready;

    ecc_syndrome_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    ecc_syndrome_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .cnt_clr(cnt_clr), .sec_cnt(sec_cnt_s), .ded_cnt(ded_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {sec, ded, mask} derived from the code rules: syndrome is the XOR of
    // the indices of all set positions, pa is the overall bit-count parity.
    function automatic logic [14:0] model(input logic [12:0] cw);
        int s = 0;
        int pa;
        for (int p = 1; p <= 12; p++) if (cw[p]) s = s ^ p;
        pa = $countones(cw) % 2;
        if (pa == 0) return (s == 0) ? 15'h0 : {2'b01, 13'h0};
        if (s == 0) return {2'b10, 13'h0001};
        if (s > 12) return {2'b01, 13'h0};
        return {2'b10, 13'(1 << s)};
    endfunction

    typedef struct {
        logic [12:0] cw;
        logic [14:0] e;
    } exp_t;

    exp_t        q[$];
    logic [12:0] hs_log[$];
    int          m_sec16, m_ded16, m_sec2, m_ded2;
    logic        held = 1'b0;
    logic [27:0] prev_out;

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            m_sec16 = 0; m_ded16 = 0; m_sec2 = 0; m_ded2 = 0;
            held = 1'b0;
            check("rst_out_valid", bus.out_valid, 0);
        end else begin
            check("sec_cnt", sec_cnt, m_sec16);
            check("ded_cnt", ded_cnt, m_ded16);
            check("sec_cnt_w2", sec_cnt_s, m_sec2);
            check("ded_cnt_w2", ded_cnt_s, m_ded2);
            check("twin_lockstep",
                  {bus2.out_valid, bus2.in_ready, bus2.out_cw, bus2.out_mask, bus2.out_sec, bus2.out_ded},
                  {bus.out_valid, bus.in_ready, bus.out_cw, bus.out_mask, bus.out_sec, bus.out_ded});
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out", bus.out_valid, 0);
                end else begin
                    check("out_cw", bus.out_cw, q[0].cw);
                    check("out_mask", bus.out_mask, q[0].e[12:0]);
                    check("out_sec", bus.out_sec, q[0].e[14]);
                    check("out_ded", bus.out_ded, q[0].e[13]);
                end
                if (held)
                    check("stall_stable", {bus.out_cw, bus.out_mask, bus.out_sec, bus.out_ded}, prev_out);
            end
            if (bus.in_valid && bus.in_ready) q.push_back('{bus.in_cw, model(bus.in_cw)});
            if (cnt_clr) begin
                m_sec16 = 0; m_ded16 = 0; m_sec2 = 0; m_ded2 = 0;
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                hs_log.push_back(q[0].e[12:0]);
                if (!cnt_clr && q[0].e[14]) begin
                    m_sec16 = sat(m_sec16, 65535); m_sec2 = sat(m_sec2, 3);
                end
                if (!cnt_clr && q[0].e[13]) begin
                    m_ded16 = sat(m_ded16, 65535); m_ded2 = sat(m_ded2, 3);
                end
                void'(q.pop_front());
            end
            held = bus.out_valid && !bus.out_ready;
            prev_out = {bus.out_cw, bus.out_mask, bus.out_sec, bus.out_ded};
        end
    end

    task automatic send(input logic [12:0] cw);
        logic rdy;
        int   n = 0;
        bus.in_valid = 1'b1;
        bus.in_cw    = cw;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        check("send_accept", rdy, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_cw     = '0;
        bus.out_ready = 1'b1;
        idle(2);
        check("rst_hold_mask", bus.out_mask, 0);
        reset_n = 1'b1;
        idle(1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_sec_cnt", sec_cnt, 0);

        // clean word, two-stage latency
        send(13'h0000);
        check("lat_not_yet", bus.out_valid, 0);
        idle(1);
        check("lat_valid", bus.out_valid, 1);
        check("clean_mask", bus.out_mask, 0);
        check("clean_flags", {bus.out_sec, bus.out_ded}, 2'b00);
        idle(3);
        check("clean_cnt", {sec_cnt, ded_cnt}, 0);

        // single error at position 5, then overall-parity bit, back to back
        send(13'h0020);
        send(13'h0001);
        check("sec1_mask", bus.out_mask, 13'h0020);
        check("sec1_flag", bus.out_sec, 1);
        idle(1);
        check("sec2_mask", bus.out_mask, 13'h0001);
        check("sec2_flag", bus.out_sec, 1);
        idle(3);
        check("sec_cnt_2", sec_cnt, 2);

        // double error (s=6,pa=0) and out-of-range syndrome (s=13,pa=1)
        send(13'h0028);
        idle(1);
        check("ded1", {bus.out_mask, bus.out_sec, bus.out_ded}, {13'h0, 2'b01});
        send(13'h0112);
        idle(1);
        check("ded2", {bus.out_mask, bus.out_sec, bus.out_ded}, {13'h0, 2'b01});
        idle(3);
        check("ded_cnt_2", ded_cnt, 2);

        // backpressure: two words buffer, then input stalls
        hs_log.delete();
        bus.out_ready = 1'b0;
        send(13'h0000);
        send(13'h0004);
        check("bp_in_ready_low", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_cw    = 13'h0000;
        idle(2);
        check("bp_in_ready_still_low", bus.in_ready, 0);
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_cw", bus.out_cw, 13'h0000);
        bus.out_ready = 1'b1;
        send(13'h0000);
        send(13'h0100);
        send(13'h0000);
        idle(5);
        check("bp_count", hs_log.size(), 5);
        if (hs_log.size() == 5) begin
            check("bp_order0", hs_log[0], 13'h0000);
            check("bp_order1", hs_log[1], 13'h0004);
            check("bp_order2", hs_log[2], 13'h0000);
            check("bp_order3", hs_log[3], 13'h0100);
            check("bp_order4", hs_log[4], 13'h0000);
        end

        // saturation on the 2-bit twin, then clear racing an increment
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        repeat (5) send(13'h0020);
        idle(4);
        check("sat_w2", sec_cnt_s, 3);
        check("sat_w16", sec_cnt, 5);
        send(13'h0020);
        idle(1);
        check("clr_race_vld", bus.out_valid, 1);
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        check("clr_w16", sec_cnt, 0);
        check("clr_w2", sec_cnt_s, 0);

        // asynchronous reset with both stages occupied
        bus.out_ready = 1'b0;
        send(13'h0020);
        send(13'h0004);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_out", {bus.out_cw, bus.out_mask, bus.out_sec, bus.out_ded}, 0);
        check("mid_rst_cnt", {sec_cnt, ded_cnt}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(3);
        check("no_stale", bus.out_valid, 0);
        send(13'h0020);
        idle(1);
        check("post_rst_mask", bus.out_mask, 13'h0020);
        check("post_rst_cw", bus.out_cw, 13'h0020);
        idle(3);
        check("q_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
